// File: rtl/window_ram_if.sv
// Request/response bundle between the DMA-side requester and window_ram.
// Data words are two's-complement 16-bit; window is indexed [row][col].
interface window_ram_if;
    logic                   RAM_enable;
    logic                   RAM_write;
    logic [15:0]            RAM_address;
    logic [15:0]            RAM_offset;
    logic [15:0]            RAM_output_data;
    logic                   RAM_finish;
    logic [4:0][4:0][15:0]  RAM_input_data;
    logic                   busy;

    modport master (
        output RAM_enable, RAM_write, RAM_address, RAM_offset, RAM_output_data,
        input  RAM_finish, RAM_input_data, busy
    );

    modport slave (
        input  RAM_enable, RAM_write, RAM_address, RAM_offset, RAM_output_data,
        output RAM_finish, RAM_input_data, busy
    );
endinterface

// File: rtl/window_ram.sv
// Word memory serving 5x5 strided window reads (one element per cycle) and single-word writes.
// Define WINDOW_RAM_ZERO_PAD_EN to read out-of-range indices as 0 and drop such writes.
module window_ram #(
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input logic         clk,
    input logic         reset,
    window_ram_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    state_e                state_q, state_d;
    logic [2:0]            row_q, row_d, col_q, col_d;
    logic [31:0]           base_q, base_d;
    logic [15:0]           offset_q, offset_d, wdata_q, wdata_d;
    logic [4:0][4:0][15:0] win_q, win_d;
    logic                  finish_q, finish_d, busy_q, busy_d;

    logic [15:0]           mem [DEPTH];
    logic [31:0]           idx32;
    logic [ADDR_W-1:0]     idx;
    logic                  in_range;
    logic [15:0]           rd_data;
    logic                  we;

    // base_q tracks address + row*offset, so no multiplier is needed; writes reuse it with col 0.
    assign idx32 = base_q + {29'd0, col_q};
    assign idx   = idx32[ADDR_W-1:0];

`ifdef WINDOW_RAM_ZERO_PAD_EN
    assign in_range = ((idx32 >> ADDR_W) == 32'd0);
`else
    logic unused_idx;
    assign unused_idx = ^(idx32 >> ADDR_W);
    assign in_range   = 1'b1;
`endif

    assign rd_data = in_range ? mem[idx] : 16'd0;
    assign we      = (state_q == StWrite) && in_range;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        base_d   = base_q;
        offset_d = offset_q;
        wdata_d  = wdata_q;
        win_d    = win_q;
        case (state_q)
            StIdle: begin
                if (bus.RAM_enable) begin
                    base_d   = {16'd0, bus.RAM_address};
                    offset_d = bus.RAM_offset;
                    wdata_d  = bus.RAM_output_data;
                    row_d    = 3'd0;
                    col_d    = 3'd0;
                    state_d  = bus.RAM_write ? StWrite : StRead;
                end
            end
            StRead: begin
                win_d[row_q][col_q] = rd_data;
                if (col_q == 3'd4) begin
                    col_d  = 3'd0;
                    row_d  = row_q + 3'd1;
                    base_d = base_q + {16'd0, offset_q};
                    if (row_q == 3'd4) begin
                        row_d   = 3'd0;
                        state_d = StDone;
                    end
                end else begin
                    col_d = col_q + 3'd1;
                end
            end
            StWrite: state_d = StDone;
            StDone: begin
                if (!bus.RAM_enable) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d   = (state_d == StRead) || (state_d == StWrite);
        finish_d = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            row_q    <= 3'd0;
            col_q    <= 3'd0;
            base_q   <= 32'd0;
            offset_q <= 16'd0;
            wdata_q  <= 16'd0;
            win_q    <= '0;
            finish_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            base_q   <= base_d;
            offset_q <= offset_d;
            wdata_q  <= wdata_d;
            win_q    <= win_d;
            finish_q <= finish_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.RAM_finish     = finish_q;
    assign bus.busy           = busy_q;
    assign bus.RAM_input_data = win_q;
endmodule

// File: tb/tb_window_ram.sv
// Randomized bench for window_ram with a transaction-level reference model and per-cycle compare.
module tb_window_ram;
    localparam int unsigned DEPTH = 4096;

    logic clk;
    logic reset;
    window_ram_if bus ();

    window_ram #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: an operation is just "busy for N cycles, then done"; the window is
    // computed in one go from the address formula when the read completes.
    logic [15:0]           m_mem [DEPTH];
    logic [4:0][4:0][15:0] m_win;
    bit                    m_active, m_done, m_wr;
    int unsigned           m_cnt, m_addr, m_off;
    logic [15:0]           m_data;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_win(input string name, input logic [4:0][4:0][15:0] act,
                             input logic [4:0][4:0][15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_rd(input longint unsigned idx);
`ifdef WINDOW_RAM_ZERO_PAD_EN
        if (idx >= DEPTH) return 16'h0000;
        return m_mem[int'(idx)];
`else
        return m_mem[int'(idx % DEPTH)];
`endif
    endfunction

    function automatic void m_write(input longint unsigned idx, input logic [15:0] d);
`ifdef WINDOW_RAM_ZERO_PAD_EN
        if (idx < DEPTH) m_mem[int'(idx)] = d;
`else
        m_mem[int'(idx % DEPTH)] = d;
`endif
    endfunction

    function automatic void m_fill_window();
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                m_win[r][c] = m_rd(longint'(m_addr) + longint'(r) * longint'(m_off) + longint'(c));
            end
        end
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_win    = '0;
        end else if (m_active) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_active = 1'b0;
                m_done   = 1'b1;
                if (m_wr) m_write(longint'(m_addr), m_data);
                else m_fill_window();
            end
        end else if (m_done) begin
            if (!bus.RAM_enable) m_done = 1'b0;
        end else if (bus.RAM_enable) begin
            m_wr     = bus.RAM_write;
            m_addr   = int'(bus.RAM_address);
            m_off    = int'(bus.RAM_offset);
            m_data   = bus.RAM_output_data;
            m_active = 1'b1;
            m_cnt    = m_wr ? 1 : 25;
        end
        #1;
        check("busy", {31'd0, bus.busy}, {31'd0, m_active});
        check("finish", {31'd0, bus.RAM_finish}, {31'd0, m_done});
        if (!m_active) check_win("window", bus.RAM_input_data, m_win);
    end

    task automatic do_req(input bit wr, input logic [15:0] addr, input logic [15:0] off,
                          input logic [15:0] data, input bit scramble, output int lat);
        @(negedge clk);
        bus.RAM_enable      = 1'b1;
        bus.RAM_write       = wr;
        bus.RAM_address     = addr;
        bus.RAM_offset      = off;
        bus.RAM_output_data = data;
        @(posedge clk);
        lat = 0;
        while (lat < 40) begin
            if (scramble) begin
                #1;
                bus.RAM_address     = 16'($urandom_range(0, 65535));
                bus.RAM_offset      = 16'($urandom_range(0, 65535));
                bus.RAM_output_data = 16'($urandom_range(0, 65535));
                bus.RAM_write       = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
            lat++;
            if (bus.RAM_finish) break;
        end
        if (!bus.RAM_finish) check("finish_timeout", 32'd0, 32'd1);
    endtask

    task automatic release_req();
        @(negedge clk);
        bus.RAM_enable = 1'b0;
        @(posedge clk);
    endtask

    int                    lat;
    logic [15:0]           exp_pad;
    logic [4:0][4:0][15:0] zero_win;

    initial begin
        zero_win            = '0;
        reset               = 1'b1;
        bus.RAM_enable      = 1'b0;
        bus.RAM_write       = 1'b0;
        bus.RAM_address     = 16'd0;
        bus.RAM_offset      = 16'd0;
        bus.RAM_output_data = 16'd0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'd0;
        #1;
        check("rst_finish", {31'd0, bus.RAM_finish}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check_win("rst_window", bus.RAM_input_data, zero_win);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Preload mem[i] = i through the write path.
        for (int i = 0; i < DEPTH; i++) begin
            do_req(1'b1, 16'(i), 16'd0, 16'(i), 1'b0, lat);
            release_req();
        end

        // Reset in the middle of a read.
        @(negedge clk);
        bus.RAM_enable  = 1'b1;
        bus.RAM_write   = 1'b0;
        bus.RAM_address = 16'd0;
        bus.RAM_offset  = 16'd5;
        @(posedge clk);
        repeat (12) @(posedge clk);
        @(negedge clk);
        reset          = 1'b1;
        bus.RAM_enable = 1'b0;
        #1;
        check("midrst_finish", {31'd0, bus.RAM_finish}, 32'd0);
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check_win("midrst_window", bus.RAM_input_data, zero_win);
        @(negedge clk);
        reset = 1'b0;
        do_req(1'b0, 16'd0, 16'd5, 16'd0, 1'b0, lat);
        check("fresh_00", {16'd0, bus.RAM_input_data[0][0]}, 32'd0);
        check("fresh_23", {16'd0, bus.RAM_input_data[2][3]}, 32'd13);
        check("fresh_31", {16'd0, bus.RAM_input_data[3][1]}, 32'd16);
        check("fresh_44", {16'd0, bus.RAM_input_data[4][4]}, 32'd24);
        release_req();

        // Strided read.
        do_req(1'b0, 16'd100, 16'd28, 16'd0, 1'b0, lat);
        check("stride_lat", lat, 32'd25);
        check("stride_00", {16'd0, bus.RAM_input_data[0][0]}, 32'd100);
        check("stride_04", {16'd0, bus.RAM_input_data[0][4]}, 32'd104);
        check("stride_40", {16'd0, bus.RAM_input_data[4][0]}, 32'd212);
        check("stride_44", {16'd0, bus.RAM_input_data[4][4]}, 32'd216);
        release_req();

        // Write then read back; the write must leave the held window alone.
        do_req(1'b1, 16'd37, 16'd0, 16'hFF9C, 1'b0, lat);
        check("write_lat", lat, 32'd1);
        check("write_keeps_win", {16'd0, bus.RAM_input_data[0][0]}, 32'd100);
        release_req();
        do_req(1'b0, 16'd37, 16'd1, 16'd0, 1'b0, lat);
        check("readback_00", {16'd0, bus.RAM_input_data[0][0]}, 32'h0000FF9C);
        check("readback_01", {16'd0, bus.RAM_input_data[0][1]}, 32'd38);
        release_req();

        // Handshake: enable held past finish, one-cycle drop, immediate re-request.
        do_req(1'b0, 16'd300, 16'd10, 16'd0, 1'b0, lat);
        repeat (10) begin
            @(posedge clk);
            #1;
            check("hold_finish", {31'd0, bus.RAM_finish}, 32'd1);
            check("hold_busy", {31'd0, bus.busy}, 32'd0);
            check("hold_12", {16'd0, bus.RAM_input_data[1][2]}, 32'd312);
        end
        @(negedge clk);
        bus.RAM_enable = 1'b0;
        @(posedge clk);
        #1;
        check("drop_finish", {31'd0, bus.RAM_finish}, 32'd0);
        do_req(1'b0, 16'd400, 16'd7, 16'd0, 1'b0, lat);
        check("rereq_lat", lat, 32'd25);
        check("rereq_43", {16'd0, bus.RAM_input_data[4][3]}, 32'd431);
        release_req();

        // Inputs scrambled every cycle during the read.
        do_req(1'b0, 16'd200, 16'd3, 16'd0, 1'b1, lat);
        check("stable_00", {16'd0, bus.RAM_input_data[0][0]}, 32'd200);
        check("stable_21", {16'd0, bus.RAM_input_data[2][1]}, 32'd207);
        check("stable_44", {16'd0, bus.RAM_input_data[4][4]}, 32'd216);
        release_req();

        // Boundary at the top of the array; mem[0] made non-zero so wrap is visible.
        do_req(1'b1, 16'd0, 16'd0, 16'h1234, 1'b0, lat);
        release_req();
        do_req(1'b0, 16'd4094, 16'd1, 16'd0, 1'b0, lat);
`ifdef WINDOW_RAM_ZERO_PAD_EN
        exp_pad = 16'h0000;
`else
        exp_pad = 16'h1234;
`endif
        check("edge_00", {16'd0, bus.RAM_input_data[0][0]}, 32'd4094);
        check("edge_01", {16'd0, bus.RAM_input_data[0][1]}, 32'd4095);
        check("edge_02", {16'd0, bus.RAM_input_data[0][2]}, {16'd0, exp_pad});
        check("edge_10", {16'd0, bus.RAM_input_data[1][0]}, 32'd4095);
        release_req();

        // Random traffic against the model.
        for (int n = 0; n < 80; n++) begin
            logic [15:0] a, o, d;
            bit          w, s;
            w = ($urandom_range(0, 3) == 0);
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       a = 16'($urandom_range(0, 65535));
                1:       a = 16'($urandom_range(4090, 4095));
                default: a = 16'($urandom_range(0, 4095));
            endcase
            o = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 65535))
                                            : 16'($urandom_range(0, 64));
            d = 16'($urandom_range(0, 65535));
            do_req(w, a, o, d, s, lat);
            check("rand_lat", lat, w ? 32'd1 : 32'd25);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            release_req();
        end

        repeat (3) @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/window_ram.md
# window_ram

Multi-cycle on-chip word memory sitting directly downstream of the DMA engine. It serves two kinds of request over a level-sensitive enable/finish handshake:
- a 5x5 window read (25 signed 16-bit words, row stride `offset`), used for feature-map tiles, filters and bias chunks;
- a single-word write of CNN results.

The array is not reset. Preload in simulation is handled outside this block.

## Interface
Parameters:
- `DEPTH`, 4096: number of 16-bit words; must be a power of two.
- `ADDR_W`, $clog2(DEPTH): internal index width.

Ports:
- `clk` in 1: sole clock; all state changes on posedge.
- `reset` in 1: asynchronous, active-high reset.
- `RAM_enable` in 1: request valid; level, held until `RAM_finish` is seen.
- `RAM_write` in 1: 1 = single-word write, 0 = 5x5 window read. Sampled with `RAM_enable`.
- `RAM_address` in 16: base address, treated as unsigned.
- `RAM_offset` in 16: row stride for reads, treated as unsigned.
- `RAM_output_data` in 16: write data (signed shortint).
- `RAM_finish` out 1: operation complete; level.
- `RAM_input_data` out 5x5x16: read window, `[row][col]`, signed shortint.
- `busy` out 1: high in READ or WRITE.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE, `RAM_enable`=1 at posedge:
  - latch address, offset, write flag and write data;
  - go to WRITE if write flag = 1, otherwise READ with element counter k=0.
- READ, each posedge:
  - capture `RAM_input_data[r][c]` = mem[idx], where r=k/5, c=k%5;
  - idx = (address + r*offset + c), computed in 32-bit unsigned, then mapped per Configuration;
  - k increments; after k=24 is captured, go to DONE.
- WRITE: at the next posedge, mem[idx(address)] <= write data, then go to DONE.
- DONE:
  - `RAM_finish`=1;
  - `RAM_input_data` is held stable until the next read completes;
  - when `RAM_enable`=0 at a posedge, return to IDLE.
- `RAM_enable` held high in DONE never restarts an operation. The requester must drop enable for at least one posedge between requests.
- Changes to address, offset, data or write in READ, WRITE or DONE are ignored; the latched copies are used.
- `RAM_enable` falling during READ or WRITE is ignored: the operation completes and DONE is entered. If enable is already low, DONE exits on the following posedge, giving a one-cycle finish pulse.
- A write never modifies `RAM_input_data`.

## Timing
- Reset (async, any state, including mid-READ or mid-WRITE):
  - state=IDLE, k=0, `RAM_finish`=0, `busy`=0, `RAM_input_data` all 0;
  - memory contents unchanged;
  - an interrupted write does not occur if reset asserts before its write edge.
- Read latency:
  - enable sampled at edge E0;
  - elements captured at E1..E25;
  - `RAM_finish`=1 after E25, i.e. 25 cycles after E0.
- Write latency: enable at E0, array written at E1, `RAM_finish`=1 after E1.
- `RAM_finish` falls after the first posedge in DONE that sees `RAM_enable`=0.
- `busy` is a registered state decode: high from after E0 until DONE is entered.
- Earliest next request: the posedge after the DONE→IDLE edge, provided enable is high there.

## Configuration
- `WINDOW_RAM_ZERO_PAD_EN` defined:
  - any element index >= DEPTH (before truncation) reads as 0;
  - a write to such an index is dropped, but finish still completes normally.
  - Used for zero-padding convolution borders.
- `WINDOW_RAM_ZERO_PAD_EN` undefined: index = low ADDR_W bits, so addresses wrap modulo DEPTH. No padding.

## Test plan
- Reset mid-READ:
  - preload mem[i]=i, read address=0, offset=5;
  - assert reset at k=12 → `RAM_finish`=0 and `RAM_input_data` all 0 immediately;
  - a fresh read then returns `[r][c]`=5r+c.
- Stride read:
  - mem[i]=i, address=100, offset=28, enable held;
  - `RAM_finish` rises exactly 25 cycles after the sampling edge;
  - `[0][0]`=100, `[0][4]`=104, `[4][0]`=212, `[4][4]`=216.
- Write then readback:
  - write 16'shFF9C (-100) to address 37: finish after 1 cycle;
  - drop enable, then read address=37, offset=1 → `[0][0]`=-100;
  - earlier window unchanged until this read completes.
- Handshake:
  - enable held 10 cycles past finish → finish stays high, no re-read, `busy`=0;
  - enable dropped for one cycle → finish low;
  - enable raised immediately → new read accepted.
- Input stability: change address and offset every cycle during READ → window reflects only the values latched at E0.
- Boundary, DEPTH=4096, address=4094, offset=1:
  - `WINDOW_RAM_ZERO_PAD_EN` defined: `[0][0]`=mem[4094], `[0][1]`=mem[4095], `[0][2]`=0, `[1][0]`=mem[4095];
  - undefined: `[0][2]`=mem[0].
